// File: rtl/fifo_mem_pkg.sv
// Shared types and helpers for the FIFO pointer/enable controller.
package fifo_mem_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  // Pointer width for a given depth: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ptr_counter.sv
// Wrap-bit pointer counter: advances by one on each enabled edge, rolls over at 2*depth.
module ptr_counter #(
  parameter int PTR_SIZE = 3
) (
  input  logic              clk_in,
  input  logic              areset,
  input  logic              en_i,
  output logic [PTR_SIZE:0] ptr_o
);

  logic [PTR_SIZE:0] ptr_q;
  logic [PTR_SIZE:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + {{PTR_SIZE{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/enable controller: gates RAM enables from requests, tracks pointers,
// decodes status, and runs a drain-all flush sequence.
module fifo_ptr_ctrl
  import fifo_mem_pkg::*;
#(
  parameter int OSTD_NUM = 8,
  parameter int PTR_SIZE = $clog2(OSTD_NUM)
) (
  input  logic              clk_in,
  input  logic              areset,
  input  logic              trans_read,
  input  logic              trans_write,
  input  logic              flush_req,
  output logic              fifo_wenable,
  output logic              fifo_renable,
  output logic [PTR_SIZE:0] write_ptr,
  output logic [PTR_SIZE:0] read_ptr,
  output logic [PTR_SIZE:0] occupancy,
  output logic              full,
  output logic              empty,
  output logic              rdata_valid,
  output logic              flush_busy,
  output logic              wr_reject,
  output logic              rd_reject
);

  localparam int PTR_W = ptr_width(OSTD_NUM);
  localparam logic [PTR_W-1:0] OCC_ONE = PTR_W'(1);

  ctrl_state_e state_q, state_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        wr_reject_q, wr_reject_d;
  logic        rd_reject_q, rd_reject_d;
  logic [PTR_W-1:0] occ;

  ptr_counter #(.PTR_SIZE(PTR_SIZE)) u_wr_ptr (
    .clk_in (clk_in),
    .areset (areset),
    .en_i   (fifo_wenable),
    .ptr_o  (write_ptr)
  );

  ptr_counter #(.PTR_SIZE(PTR_SIZE)) u_rd_ptr (
    .clk_in (clk_in),
    .areset (areset),
    .en_i   (fifo_renable),
    .ptr_o  (read_ptr)
  );

  // Status decode from the registered pointers
  assign occ       = write_ptr - read_ptr;
  assign occupancy = occ;
  assign empty     = (write_ptr == read_ptr);
  assign full      = (write_ptr[PTR_SIZE] != read_ptr[PTR_SIZE]) &&
                     (write_ptr[PTR_SIZE-1:0] == read_ptr[PTR_SIZE-1:0]);

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Exit on occupancy 1 so the final drain read lands on the same edge as the exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (empty || (occ == OCC_ONE)) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    fifo_wenable  = 1'b0;
    fifo_renable  = 1'b0;
    rdata_valid_d = 1'b0;
    if (!areset) begin
      if (state_q == ST_RUN) begin
        fifo_wenable = trans_write && !full;
        fifo_renable = trans_read && !empty;
      end else begin
        fifo_renable = !empty;
      end
    end
    // Flush reads discard their data, so only run-mode reads produce valid data
    rdata_valid_d = (state_q == ST_RUN) && fifo_renable;
    wr_reject_d   = trans_write && !fifo_wenable;
    rd_reject_d   = trans_read && !rdata_valid_d;
  end

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      rdata_valid_q <= 1'b0;
      wr_reject_q   <= 1'b0;
      rd_reject_q   <= 1'b0;
    end else begin
      rdata_valid_q <= rdata_valid_d;
      wr_reject_q   <= wr_reject_d;
      rd_reject_q   <= rd_reject_d;
    end
  end

  assign rdata_valid = rdata_valid_q;
  assign wr_reject   = wr_reject_q;
  assign rd_reject   = rd_reject_q;
  assign flush_busy  = (state_q == ST_FLUSH);

endmodule
